// File: rtl/otter_dmem_bridge.sv
// otter_dmem_bridge: single-transaction Wishbone-classic master for the OTTER
// MEM stage. Takes an aligned word request, runs one bus cycle, stalls the core
// until ack/err, then presents the raw read word and an error flag for one
// cycle (DONE).
// Optional feature macro: OTTER_DMEM_TIMEOUT_EN -- when defined, a wait counter
// aborts a bus cycle after TIMEOUT_CYCLES cycles without ack/err.
module otter_dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [3:0]  i_req_sel,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_w_data,
  output logic        o_stall,
  output logic [31:0] o_r_data,
  output logic        o_err,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic        wb_cyc_q;
  logic        wb_we_q;
  logic [3:0]  wb_sel_q;
  logic [31:0] wb_adr_q;
  logic [31:0] wb_dat_q;
  logic [31:0] r_data_q;
  logic        err_q;
  logic        timeout_hit;

  // The low address bits are byte offsets already folded into the lane select.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^i_req_addr[1:0];

`ifdef OTTER_DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_q;
  logic [CNT_W-1:0] wait_d;

  // Wait counter next value and terminal-cycle detect.
  assign wait_d      = wait_q + 1'b1;
  assign timeout_hit = (wait_q == WAIT_LAST);
`else
  // Without the timeout the bus cycle waits indefinitely for ack/err.
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_CYCLES;
  assign timeout_hit          = 1'b0;
`endif

  // Pipeline is held while a request is pending and its result is not yet shown.
  assign o_stall = i_req_valid & (state_q != S_DONE);

  assign o_wb_cyc = wb_cyc_q;
  assign o_wb_stb = wb_cyc_q;
  assign o_wb_we  = wb_we_q;
  assign o_wb_sel = wb_sel_q;
  assign o_wb_adr = wb_adr_q;
  assign o_wb_dat = wb_dat_q;
  assign o_r_data = r_data_q;
  assign o_err    = err_q;

  // Bridge FSM with registered bus and result outputs.
  // NOTE: non-blocking assignments so every branch reads pre-edge register values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      wb_cyc_q <= 1'b0;
      wb_we_q  <= 1'b0;
      wb_sel_q <= 4'b0;
      wb_adr_q <= 32'b0;
      wb_dat_q <= 32'b0;
      r_data_q <= 32'b0;
      err_q    <= 1'b0;
`ifdef OTTER_DMEM_TIMEOUT_EN
      wait_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_req_valid) begin
            if (i_req_sel != 4'b0) begin
              wb_cyc_q <= 1'b1;
              wb_we_q  <= i_req_we;
              wb_sel_q <= i_req_sel;
              wb_adr_q <= {i_req_addr[31:2], 2'b00};
              wb_dat_q <= i_req_w_data;
`ifdef OTTER_DMEM_TIMEOUT_EN
              wait_q   <= '0;
`endif
              state_q  <= S_BUS;
            end else begin
              // An empty lane select can never complete on the bus.
              err_q    <= 1'b1;
              r_data_q <= 32'b0;
              state_q  <= S_DONE;
            end
          end
        end
        S_BUS: begin
          if (i_wb_err) begin
            wb_cyc_q <= 1'b0;
            err_q    <= 1'b1;
            r_data_q <= 32'b0;
            state_q  <= S_DONE;
          end else if (i_wb_ack) begin
            wb_cyc_q <= 1'b0;
            err_q    <= 1'b0;
            r_data_q <= wb_we_q ? 32'b0 : i_wb_dat;
            state_q  <= S_DONE;
          end else if (timeout_hit) begin
            wb_cyc_q <= 1'b0;
            err_q    <= 1'b1;
            r_data_q <= 32'b0;
            state_q  <= S_DONE;
          end else begin
`ifdef OTTER_DMEM_TIMEOUT_EN
            wait_q   <= wait_d;
`endif
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          wb_cyc_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otter_dmem_bridge.sv
// Self-checking bench for otter_dmem_bridge: a cycle-stepped Wishbone slave
// model plus a scoreboard of expected (read data, error) results.
module tb_otter_dmem_bridge;

  localparam int unsigned TO_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_addr;
  logic [31:0] req_w_data;
  logic        stall;
  logic [31:0] r_data;
  logic        err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack;
  logic        wb_err;

  typedef struct {
    logic [31:0] r_data;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] cyc_trace;
  int          cyc_cnt;
  int          stall_cnt;
  logic        finished;

  otter_dmem_bridge #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_we     (req_we),
    .i_req_sel    (req_sel),
    .i_req_addr   (req_addr),
    .i_req_w_data (req_w_data),
    .o_stall      (stall),
    .o_r_data     (r_data),
    .o_err        (err),
    .o_wb_cyc     (wb_cyc),
    .o_wb_stb     (wb_stb),
    .o_wb_we      (wb_we),
    .o_wb_sel     (wb_sel),
    .o_wb_adr     (wb_adr),
    .o_wb_dat     (wb_dat_o),
    .i_wb_dat     (wb_dat_i),
    .i_wb_ack     (wb_ack),
    .i_wb_err     (wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and act as the slave: ack (and err if berr) after
  // 'waits' wait states, or never if waits exceeds the budget.
  task automatic run_req(input string tag, input logic we, input logic [3:0] sel,
                         input logic [31:0] addr, input logic [31:0] wdat,
                         input logic [31:0] sdat, input int waits, input logic berr,
                         input logic to_exp, input int budget);
    exp_t e;
    req_valid  = 1'b1;
    req_we     = we;
    req_sel    = sel;
    req_addr   = addr;
    req_w_data = wdat;
    e.err      = (sel == 4'b0) || berr || to_exp;
    e.r_data   = (e.err || we) ? 32'h0 : sdat;
    e.chk_data = !(we && !e.err);
    sb_q.push_back(e);
    cyc_cnt   = 0;
    stall_cnt = 0;
    finished  = 1'b0;
    for (int c = 0; c < budget && !finished; c++) begin
      @(negedge clk);
      cyc_trace = {cyc_trace[30:0], wb_cyc};
      if (wb_cyc) begin
        cyc_cnt++;
        check({tag, ".stb"}, 32'(wb_stb), 32'd1);
        check({tag, ".adr"}, wb_adr, {addr[31:2], 2'b00});
        check({tag, ".we"},  32'(wb_we), 32'(we));
        check({tag, ".sel"}, 32'(wb_sel), 32'(sel));
        check({tag, ".dat"}, wb_dat_o, wdat);
        wb_dat_i = sdat;
        wb_ack   = (cyc_cnt > waits);
        wb_err   = berr && (cyc_cnt > waits);
      end else begin
        wb_ack = 1'b0;
        wb_err = 1'b0;
      end
      if (stall) begin
        stall_cnt++;
      end else begin
        finished = 1'b1;
        e = sb_q.pop_front();
        if (e.chk_data) check({tag, ".rdata"}, r_data, e.r_data);
        check({tag, ".err"}, 32'(err), 32'(e.err));
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wb_ack    = 1'b0;
    wb_err    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_sel    = 4'b0;
    req_addr   = 32'h0;
    req_w_data = 32'h0;
    wb_dat_i   = 32'h0;
    wb_ack     = 1'b0;
    wb_err     = 1'b0;
    cyc_trace  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.cyc",   32'(wb_cyc), 32'd0);
    check("rst.stb",   32'(wb_stb), 32'd0);
    check("rst.we",    32'(wb_we), 32'd0);
    check("rst.sel",   32'(wb_sel), 32'd0);
    check("rst.adr",   wb_adr, 32'd0);
    check("rst.dat",   wb_dat_o, 32'd0);
    check("rst.rdata", r_data, 32'd0);
    check("rst.err",   32'(err), 32'd0);
    rst = 1'b0;

    // Stray ack/err while idle must be ignored.
    wb_ack = 1'b1;
    wb_err = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ack.cyc",   32'(wb_cyc), 32'd0);
    check("idle_ack.err",   32'(err), 32'd0);
    check("idle_ack.stall", 32'(stall), 32'd0);
    wb_ack = 1'b0;
    wb_err = 1'b0;
    @(posedge clk);
    #1;

    // Load, ack on first bus cycle.
    cyc_trace = 32'h0;
    run_req("ld", 1'b0, 4'b1111, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 20);
    check("ld.done",  32'(finished), 32'd1);
    check("ld.cycs",  32'(cyc_cnt), 32'd1);
    check("ld.stall", 32'(stall_cnt), 32'd2);
    check("ld.trace", 32'(cyc_trace[2:0]), 32'b010);

    // Byte store with 3 wait states.
    run_req("st", 1'b1, 4'b0100, 32'h0000_2002, 32'h00AB_0000, 32'h1234_5678, 3, 1'b0, 1'b0, 20);
    check("st.done",  32'(finished), 32'd1);
    check("st.cycs",  32'(cyc_cnt), 32'd4);
    check("st.stall", 32'(stall_cnt), 32'd5);

    // Ack and err together after one wait state: error wins.
    run_req("be", 1'b0, 4'b0011, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 1, 1'b1, 1'b0, 20);
    check("be.cycs",  32'(cyc_cnt), 32'd2);
    check("be.stall", 32'(stall_cnt), 32'd3);

    // Empty select: no bus cycle, straight to DONE.
    run_req("sel0", 1'b0, 4'b0000, 32'h0000_4000, 32'h0, 32'h5555_AAAA, 0, 1'b0, 1'b0, 20);
    check("sel0.cycs",  32'(cyc_cnt), 32'd0);
    check("sel0.stall", 32'(stall_cnt), 32'd1);

    // Back-to-back load then store.
    cyc_trace = 32'h0;
    run_req("b2b_ld", 1'b0, 4'b1111, 32'h0000_5000, 32'h0, 32'h0BAD_F00D, 0, 1'b0, 1'b0, 20);
    run_req("b2b_st", 1'b1, 4'b1100, 32'h0000_5004, 32'hA5A5_0000, 32'h0, 0, 1'b0, 1'b0, 20);
    check("b2b.trace", 32'(cyc_trace[5:0]), 32'b010010);

    // Asynchronous reset while the bus cycle is open.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_sel    = 4'b1111;
    req_addr   = 32'h0000_6000;
    req_w_data = 32'h0;
    repeat (2) @(negedge clk);
    check("mid.cyc_before", 32'(wb_cyc), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid.cyc", 32'(wb_cyc), 32'd0);
    check("mid.stb", 32'(wb_stb), 32'd0);
    check("mid.sel", 32'(wb_sel), 32'd0);
    check("mid.adr", wb_adr, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    #1;
    run_req("post", 1'b0, 4'b1111, 32'h0000_7008, 32'h0, 32'h1357_9BDF, 1, 1'b0, 1'b0, 20);
    check("post.cycs",  32'(cyc_cnt), 32'd2);
    check("post.stall", 32'(stall_cnt), 32'd3);

`ifdef OTTER_DMEM_TIMEOUT_EN
    // No ack ever: abort after TO_CYCLES bus cycles.
    run_req("to", 1'b0, 4'b1111, 32'h0000_8000, 32'h0, 32'hFFFF_FFFF, 1000, 1'b0, 1'b1, 50);
    check("to.done",  32'(finished), 32'd1);
    check("to.cycs",  32'(cyc_cnt), TO_CYCLES);
    check("to.stall", 32'(stall_cnt), TO_CYCLES + 1);
`else
    // No ack ever: the bus cycle stays open.
    run_req("hang", 1'b0, 4'b1111, 32'h0000_8000, 32'h0, 32'hFFFF_FFFF, 1000, 1'b0, 1'b0, 110);
    check("hang.done",  32'(finished), 32'd0);
    check("hang.cyc",   32'(wb_cyc), 32'd1);
    check("hang.cycs",  32'(cyc_cnt > 100), 32'd1);
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_req("recov", 1'b0, 4'b0001, 32'h0000_9000, 32'h0, 32'h0000_00EE, 0, 1'b0, 1'b0, 20);
    check("recov.cycs", 32'(cyc_cnt), 32'd1);
`endif

    check("sb.empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/otter_dmem_bridge.md
Name: otter_dmem_bridge

Overview:
Sequential bridge that sits directly downstream of the OTTER load/store bus manager. It accepts the already-aligned word address, byte-select, and store data from the MEM stage and runs a single Wishbone-classic master transaction to data memory or peripherals. It stalls the core until the transaction completes, then returns the raw 32-bit read word for the bus manager to shift and sign-extend.

Parameters:
TIMEOUT_CYCLES, 255, number of BUS-state cycles without ack/err before abort; used only when OTTER_DMEM_TIMEOUT_EN is defined; legal range 2..65535.

Ports:
i_clk  input  1  core clock; all state updates on the rising edge
i_rst  input  1  reset, asynchronous, active-high
i_req_valid  input  1  MEM stage holds a load or store; held stable while o_stall=1
i_req_we  input  1  1=store, 0=load
i_req_sel  input  4  byte lanes, already shifted by address[1:0]
i_req_addr  input  32  word-aligned address; bits [1:0] are ignored and driven as 0 on the bus
i_req_w_data  input  32  lane-aligned store data
o_stall  output  1  freezes the pipeline while a request is outstanding
o_r_data  output  32  raw read word, valid in DONE
o_err  output  1  bus error, illegal select, or timeout; valid in DONE
o_wb_cyc  output  1  Wishbone cycle
o_wb_stb  output  1  Wishbone strobe, always equal to o_wb_cyc
o_wb_we  output  1  Wishbone write enable
o_wb_sel  output  4  Wishbone byte select
o_wb_adr  output  32  Wishbone address
o_wb_dat  output  32  Wishbone write data
i_wb_dat  input  32  Wishbone read data
i_wb_ack  input  1  Wishbone acknowledge
i_wb_err  input  1  Wishbone error

Behaviour:
- Reset (async, i_rst=1): state=IDLE; all registered outputs are 0 (o_wb_cyc/stb/we, o_wb_sel, o_wb_adr, o_wb_dat, o_r_data, o_err). Outputs drop immediately, even mid-transaction. No pending request is remembered.
- FSM states:
  - IDLE:
    - i_req_valid=1 and i_req_sel!=0: capture we/sel/addr/data into the bus registers; next state BUS.
    - i_req_valid=1 and i_req_sel==0: no bus cycle is issued; set o_err=1 and o_r_data=0; next state DONE.
    - Otherwise: stay in IDLE.
  - BUS: o_wb_cyc=o_wb_stb=1, and bus outputs hold constant.
    - i_wb_err sampled 1: o_err=1, o_r_data=0, go to DONE. Error takes priority over a simultaneous ack.
    - i_wb_ack sampled 1: o_r_data=i_wb_dat for loads (unchanged 0 for stores), o_err=0, go to DONE.
    - Neither: stay in BUS.
    - On leaving BUS, cyc/stb are registered low in the same edge.
  - DONE: one cycle only. o_r_data and o_err are presented; next state is always IDLE.
- o_stall is combinational: i_req_valid & (state != DONE). The core advances on the edge that ends DONE.
- Latency: with ack in the first BUS cycle, a request occupies 3 cycles (IDLE, BUS, DONE) and stalls for 2. Each extra wait state adds one cycle.
- Back-to-back requests: a new request is recognised in the IDLE cycle that immediately follows DONE. No bubbles beyond that.
- If i_req_valid drops mid-BUS (protocol violation): the bus transaction still completes normally and the result is discarded in DONE.
- o_r_data and o_err keep their values outside DONE until the next capture. Consumers may sample them only in DONE.
- Ack/err arriving while in IDLE or DONE is ignored.

Optional Feature:
OTTER_DMEM_TIMEOUT_EN
- Defined:
  - A wait counter (width = clog2(TIMEOUT_CYCLES+1)) clears on entry to BUS and increments each BUS cycle without ack/err.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack/err that cycle: drop cyc/stb, set o_err=1 and o_r_data=0, go to DONE.
  - An ack or err on the terminal cycle wins over the timeout.
- Undefined: no counter is synthesised, and BUS waits indefinitely for ack/err.

Test Plan:
- Load, ack on first BUS cycle: addr=0x0000_1004, sel=4'b1111, i_wb_dat=0xDEADBEEF -> cyc high exactly 1 cycle, o_wb_adr=0x0000_1004, o_stall high 2 cycles, o_r_data=0xDEADBEEF and o_err=0 in DONE.
- Byte store with 3 wait states: addr=0x0000_2002, sel=4'b0100, data=0x00AB0000 -> o_wb_we=1, o_wb_sel=4'b0100, cyc high 4 cycles, o_stall high 5 cycles.
- Error path: ack and err asserted together -> o_err=1 and o_r_data=0 in DONE. Also: sel=0 request -> no cyc, o_err=1 after 1 stall cycle.
- Reset mid-BUS: assert i_rst asynchronously with cyc=1 -> cyc/stb/sel/adr drop to 0 before the next clock edge. After release, state is IDLE and the next request completes normally.
- Back-to-back: load then store on consecutive instructions, ack on first BUS cycle each time -> cyc pattern 0,1,0,0,1,0 (IDLE/BUS/DONE ×2), with the second capture in the cycle after the first DONE.
- With OTTER_DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> cyc high exactly 4 cycles, then DONE with o_err=1 and o_r_data=0. Without the macro -> cyc stays high past 100 cycles.
